otf_digit_converter: RTL and testbench
======================================

# otf_digit_converter

On-the-fly converter that consumes the MSB-first signed-digit stream in plus/minus form produced by the online divider's digit-selection stage. It accepts one radix-2 digit in {-1,0,+1} per handshake and holds the running conventional result and its decrement in registers, so no carry-propagate adder is needed. After the configured number of digits it presents a two's-complement integer. It is the read-side counterpart of the signed-digit adders: it turns redundant plus/minus digits back into binary.

## Interface
- bits, 64, width of the result register and output.
- digits, 63, digits per conversion. Legal range 1..bits-1, which guarantees the result fits in bits-bit two's complement.
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begins a conversion; sampled only in IDLE.
- digit_valid  input  1  digit_plus/digit_minus carry a digit.
- digit_plus  input  1  plus bit of the digit.
- digit_minus  input  1  minus bit of the digit.
- digit_ready  output  1  converter accepts a digit this cycle.
- result  output  bits  two's-complement value of the digit string.
- result_valid  output  1  result is final.
- result_ready  input  1  consumer takes result.
- sign  output  1  result[bits-1]; meaningful only while result_valid is high.
- busy  output  1  high when the state is not IDLE.

## Operation
- Digit decode:
  - plus=1, minus=0 gives q=+1.
  - plus=0, minus=1 gives q=-1.
  - 00 and 11 both give q=0.
- State registers:
  - Q, bits wide.
  - QM, bits wide. Invariant: QM = Q-1 mod 2^bits.
  - cnt, clog2(digits+1) bits.
- FSM:
  - IDLE: start=1 loads Q=0, QM=all ones, cnt=0, then goes to CONVERT.
  - CONVERT: digit_ready=1. Each digit_valid&&digit_ready cycle updates as below and increments cnt. When the accepted digit makes cnt equal digits, go to DONE.
  - DONE: result_valid=1. result_ready=1 goes to IDLE.
- Update on an accepted digit. All shifts are left by 1, dropping the MSB, with the digit's bit in the LSB.
  - q=+1: Q={Q,1}, QM={Q,0}.
  - q=0: Q={Q,0}, QM={QM,1}.
  - q=-1: Q={QM,1}, QM={QM,0}.
- Value definition: result = sum q_i*2^(digits-i) for i=1..digits, i=1 first. The range is ±(2^digits-1). It is exact modulo 2^bits and needs no overflow flag.
- result is driven from Q at all times. Only the DONE value is defined.
- start outside IDLE is ignored. digit_valid outside CONVERT is ignored and is not consumed.

## Timing
- Reset values:
  - State IDLE.
  - Q=0, QM=all ones, cnt=0.
  - digit_ready=0, result_valid=0, busy=0.
  - result=0, sign=0.
- Reset is asynchronous at any point. A conversion in progress is aborted, no partial result is emitted, and the block returns to IDLE.
- From start:
  - start is sampled at edge T0, and digit_ready is high from T0+1.
  - The first digit can be accepted at the edge ending that cycle.
- Result timing:
  - result_valid rises the cycle after the edge that accepts the final digit.
  - With continuous digit_valid the minimum is digits+1 cycles from start to result_valid.
- Throughput: one digit per cycle. Gaps in digit_valid stall without changing state.
- DONE backpressure: result and result_valid hold stable until result_ready. The transfer occurs on the edge where result_valid&&result_ready. result_valid is 0 the following cycle.
- A new start is honoured no earlier than the cycle after the return to IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- Back-to-back +1 digits (bits=8, digits=7, digits held valid):
  - Stimulus: start, then seven +1 digits.
  - Required: result=0x7F, sign=0, result_valid exactly 8 cycles after start.
- Same configuration, seven -1 digits -> result=0x81 (-127), sign=1.
- Mixed digits (bits=8, digits=7):
  - Stimulus: +1 then six -1 (64-63).
  - Required: result=0x01.
  - Stimulus: -1,+1,0,0,0,0,+1.
  - Required: -64+32+1 = 0xE1.
- Zero encodings: seven digits alternating 00 and 11 -> result=0x00.
- Stalls and backpressure:
  - Stimulus: insert random digit_valid gaps, hold result_ready=0 for 5 cycles, and assert start while in DONE.
  - Required: result stable, start ignored, result_valid drops one cycle after result_ready.
- Reset mid-stream:
  - Stimulus: assert reset after 3 of 7 digits.
  - Required: immediate IDLE, all outputs at reset values. A following full conversion of +1,0,0,0,0,0,0 gives 0x40.

Source files
------------

// File: rtl/otf_digit_converter.sv
// On-the-fly converter: turns an MSB-first radix-2 signed-digit stream
// (plus/minus encoding) into a two's-complement integer without a
// carry-propagate adder. It keeps Q and QM = Q-1 and selects between them
// on every digit.
module otf_digit_converter #(
    parameter int unsigned bits   = 64,
    parameter int unsigned digits = 63
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            digit_valid,
    input  logic            digit_plus,
    input  logic            digit_minus,
    output logic            digit_ready,
    output logic [bits-1:0] result,
    output logic            result_valid,
    input  logic            result_ready,
    output logic            sign,
    output logic            busy
);

    localparam int unsigned CntW = (digits < 1) ? 1 : $clog2(digits + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(digits - 1);

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StDone
    } state_e;

    state_e            state_q;
    logic [bits-1:0]   q_q;
    logic [bits-1:0]   qm_q;
    logic [CntW-1:0]   cnt_q;
    logic [bits-1:0]   q_nxt;
    logic [bits-1:0]   qm_nxt;
    logic              q_pos;
    logic              q_neg;
    logic              accept;

    // 00 and 11 both decode to a zero digit.
    assign q_pos  = digit_plus & ~digit_minus;
    assign q_neg  = ~digit_plus & digit_minus;
    assign accept = digit_valid & digit_ready;

    // Candidate Q/QM after appending the incoming digit.
    always_comb begin
        q_nxt  = {q_q[bits-2:0], 1'b0};
        qm_nxt = {qm_q[bits-2:0], 1'b1};
        if (q_pos) begin
            q_nxt  = {q_q[bits-2:0], 1'b1};
            qm_nxt = {q_q[bits-2:0], 1'b0};
        end else if (q_neg) begin
            q_nxt  = {qm_q[bits-2:0], 1'b1};
            qm_nxt = {qm_q[bits-2:0], 1'b0};
        end
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            q_q          <= '0;
            qm_q         <= '1;
            cnt_q        <= '0;
            digit_ready  <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        q_q         <= '0;
                        qm_q        <= '1;
                        cnt_q       <= '0;
                        digit_ready <= 1'b1;
                        busy        <= 1'b1;
                        state_q     <= StConvert;
                    end
                end
                StConvert: begin
                    if (accept) begin
                        q_q   <= q_nxt;
                        qm_q  <= qm_nxt;
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == LastCnt) begin
                            digit_ready  <= 1'b0;
                            result_valid <= 1'b1;
                            state_q      <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    digit_ready  <= 1'b0;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign result = q_q;
    assign sign   = q_q[bits-1];

endmodule

// File: tb/tb_otf_digit_converter.sv
// Directed bench for otf_digit_converter with bits=8, digits=7.
module tb_otf_digit_converter;

    localparam int unsigned Bits   = 8;
    localparam int unsigned Digits = 7;

    logic            clk;
    logic            reset;
    logic            start;
    logic            digit_valid;
    logic            digit_plus;
    logic            digit_minus;
    logic            digit_ready;
    logic [Bits-1:0] result;
    logic            result_valid;
    logic            result_ready;
    logic            sign;
    logic            busy;

    int n_checks;
    int n_pass;

    otf_digit_converter #(
        .bits   (Bits),
        .digits (Digits)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .digit_valid  (digit_valid),
        .digit_plus   (digit_plus),
        .digit_minus  (digit_minus),
        .digit_ready  (digit_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sign         (sign),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start a conversion and feed digits (index Digits-1 first). Inputs change
    // on the falling edge; outputs are sampled there too. Returns the number of
    // rising edges from the start cycle until result_valid is seen. When
    // stop_after < Digits it returns right after that many digits are accepted.
    task automatic convert(input logic [Digits-1:0] p, input logic [Digits-1:0] m,
                           input bit gaps, input int stop_after, output int cycles);
        int idx;
        bit done;
        idx    = 0;
        cycles = 0;
        done   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles++;
        for (int it = 0; it < 100 && !done; it++) begin
            @(negedge clk);
            start = 1'b0;
            if (result_valid) begin
                done = 1'b1;
            end else begin
                digit_valid = 1'b0;
                if (digit_ready && idx < Digits && !(gaps && $urandom_range(0, 2) == 0)) begin
                    digit_valid = 1'b1;
                    digit_plus  = p[Digits-1-idx];
                    digit_minus = m[Digits-1-idx];
                    idx++;
                end
                @(posedge clk);
                cycles++;
                if (stop_after < int'(Digits) && idx >= stop_after) begin
                    done = 1'b1;
                end
            end
        end
        #1;
        digit_valid = 1'b0;
        if (!done) check("convert_timeout", 64'd0, 64'd1);
    endtask

    // Hold result_ready low for hold cycles (optionally asserting start),
    // checking result stays put, then complete the transfer.
    task automatic release_result(input string tag, input int hold, input bit poke_start);
        logic [Bits-1:0] held;
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            start = poke_start;
            @(posedge clk);
        end
        @(negedge clk);
        if (hold > 0) begin
            check({tag, "_hold_result"}, 64'(result), 64'(held));
            check({tag, "_hold_valid"}, 64'(result_valid), 64'd1);
        end
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start        = 1'b0;
        result_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(result_valid), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_case(input string tag, input logic [Digits-1:0] p,
                            input logic [Digits-1:0] m, input logic [Bits-1:0] exp,
                            input bit gaps, input int hold, input bit poke_start);
        int cyc;
        convert(p, m, gaps, Digits, cyc);
        check({tag, "_result"}, 64'(result), 64'(exp));
        check({tag, "_sign"}, 64'(sign), 64'(exp[Bits-1]));
        check({tag, "_rvalid"}, 64'(result_valid), 64'd1);
        if (!gaps) check({tag, "_latency"}, 64'(cyc), 64'(Digits + 1));
        release_result(tag, hold, poke_start);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 64'(digit_ready), 64'd0);
        check({tag, "_rvalid"}, 64'(result_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_sign"}, 64'(sign), 64'd0);
    endtask

    initial begin
        int cyc;
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        start        = 1'b0;
        digit_valid  = 1'b0;
        digit_plus   = 1'b0;
        digit_minus  = 1'b0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Seven +1 digits: 127.
        run_case("all_plus", 7'h7F, 7'h00, 8'h7F, 1'b0, 0, 1'b0);
        // Seven -1 digits: -127.
        run_case("all_minus", 7'h00, 7'h7F, 8'h81, 1'b0, 0, 1'b0);
        // +1 then six -1: 64-63 = 1.
        run_case("plus_then_minus", 7'h40, 7'h3F, 8'h01, 1'b0, 0, 1'b0);
        // -1,+1,0,0,0,0,+1: -64+32+1 = -31.
        run_case("mixed", 7'h21, 7'h40, 8'hE1, 1'b0, 0, 1'b0);
        // Alternating 00 / 11 encodings of zero.
        run_case("zeros", 7'h2A, 7'h2A, 8'h00, 1'b0, 0, 1'b0);
        // +1,0,+1,-1,+1,-1,+1 = 64+16-8+4-2+1 = 75, with gaps, backpressure and
        // a start pulse held during DONE.
        run_case("stall_bp", 7'h55, 7'h0A, 8'h4B, 1'b1, 5, 1'b1);

        // Abort after three of seven digits.
        convert(7'h7F, 7'h00, 1'b0, 3, cyc);
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        run_case("after_reset", 7'h40, 7'h00, 8'h40, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
